// File: rtl/mem_arb.sv
// mem_arb: two-port (fetch / load-store) arbiter onto one synchronous SRAM.
// Ports: clk, rst (async high); ins_* fetch req/gnt/return; dat_* load-store
//   req/gnt/return; sram_* registered SRAM command, sram_rd read data;
//   conflict_cnt counts cycles where both ports request.
module mem_arb #(
   parameter int AW         = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ins_req,
   input  logic [AW+1:0] ins_a,
   output logic          ins_gnt,
   output logic          ins_rvalid,
   output logic [31:0]   ins_rdata,
   input  logic          dat_req,
   input  logic          dat_we,
   input  logic [3:0]    dat_be,
   input  logic [AW+1:0] dat_a,
   input  logic [31:0]   dat_wd,
   output logic          dat_gnt,
   output logic          dat_rvalid,
   output logic [31:0]   dat_rdata,
   output logic          sram_e,
   output logic [AW-1:0] sram_a,
   output logic [3:0]    sram_we,
   output logic [31:0]   sram_wd,
   input  logic [31:0]   sram_rd,
   output logic [15:0]   conflict_cnt
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [3:0]    starve_q, starve_d;
   logic [15:0]   conflict_q, conflict_d;
   logic          e_q, e_d;
   logic [AW-1:0] a_q, a_d;
   logic [3:0]    we_q, we_d;
   logic [31:0]   wd_q, wd_d;
   // tag = {is_read, is_data}; stage 1 rides with the command, stage 2
   // lines up with the cycle in which sram_rd carries the read data.
   logic [1:0]    tag1_q, tag1_d;
   logic [1:0]    tag2_q, tag2_d;
   logic          irv_q, irv_d;
   logic          drv_q, drv_d;
   logic [31:0]   ird_q, ird_d;
   logic [31:0]   drd_q, drd_d;

   logic both;
   logic unused_addr_lsb;

   assign both            = ins_req & dat_req;
   assign unused_addr_lsb = ^{ins_a[1:0], dat_a[1:0]};

   // Data normally wins; a starved fetch takes one slot.
   always_comb begin
      ins_gnt = 1'b0;
      dat_gnt = 1'b0;
      if (!rst) begin
         if (both) begin
            if (starve_q == SMAX) ins_gnt = 1'b1;
            else                  dat_gnt = 1'b1;
         end else if (ins_req) begin
            ins_gnt = 1'b1;
         end else if (dat_req) begin
            dat_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      starve_d   = starve_q;
      conflict_d = conflict_q;
      e_d        = ins_gnt | dat_gnt;
      a_d        = a_q;
      we_d       = 4'b0000;
      wd_d       = wd_q;
      tag1_d     = 2'b00;
      tag2_d     = tag1_q;
      irv_d      = 1'b0;
      drv_d      = 1'b0;
      ird_d      = ird_q;
      drd_d      = drd_q;

      if (!ins_req || ins_gnt)  starve_d = 4'd0;
      else if (starve_q != SMAX) starve_d = starve_q + 4'd1;

      if (both && conflict_q != 16'hFFFF)
         conflict_d = conflict_q + 16'd1;

      if (ins_gnt) begin
         a_d    = ins_a[AW+1:2];
         tag1_d = 2'b10;
      end else if (dat_gnt) begin
         a_d    = dat_a[AW+1:2];
         we_d   = dat_we ? dat_be : 4'b0000;
         wd_d   = dat_wd;
         tag1_d = {~dat_we, 1'b1};
      end

      if (tag2_q == 2'b10) begin
         irv_d = 1'b1;
         ird_d = sram_rd;
      end
      if (tag2_q == 2'b11) begin
         drv_d = 1'b1;
         drd_d = sram_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q   <= '0;
         conflict_q <= '0;
         e_q        <= 1'b0;
         a_q        <= '0;
         we_q       <= '0;
         wd_q       <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
         irv_q      <= 1'b0;
         drv_q      <= 1'b0;
         ird_q      <= '0;
         drd_q      <= '0;
      end else begin
         starve_q   <= starve_d;
         conflict_q <= conflict_d;
         e_q        <= e_d;
         a_q        <= a_d;
         we_q       <= we_d;
         wd_q       <= wd_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag2_d;
         irv_q      <= irv_d;
         drv_q      <= drv_d;
         ird_q      <= ird_d;
         drd_q      <= drd_d;
      end
   end

   assign sram_e       = e_q;
   assign sram_a       = a_q;
   assign sram_we      = we_q;
   assign sram_wd      = wd_q;
   assign ins_rvalid   = irv_q;
   assign ins_rdata    = ird_q;
   assign dat_rvalid   = drv_q;
   assign dat_rdata    = drd_q;
   assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vector table plus multi-cycle sequences for mem_arb.
// Includes a small behavioural SRAM driving sram_rd one cycle after a read.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ins_req;
   logic [15:0] ins_a;
   logic        ins_gnt, ins_rvalid;
   logic [31:0] ins_rdata;
   logic        dat_req, dat_we;
   logic [3:0]  dat_be;
   logic [15:0] dat_a;
   logic [31:0] dat_wd;
   logic        dat_gnt, dat_rvalid;
   logic [31:0] dat_rdata;
   logic        sram_e;
   logic [13:0] sram_a;
   logic [3:0]  sram_we;
   logic [31:0] sram_wd;
   logic [31:0] sram_rd = 32'h0;
   logic [15:0] conflict_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   mem_arb #(.AW(14), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .ins_req(ins_req), .ins_a(ins_a), .ins_gnt(ins_gnt),
      .ins_rvalid(ins_rvalid), .ins_rdata(ins_rdata),
      .dat_req(dat_req), .dat_we(dat_we), .dat_be(dat_be),
      .dat_a(dat_a), .dat_wd(dat_wd), .dat_gnt(dat_gnt),
      .dat_rvalid(dat_rvalid), .dat_rdata(dat_rdata),
      .sram_e(sram_e), .sram_a(sram_a), .sram_we(sram_we),
      .sram_wd(sram_wd), .sram_rd(sram_rd),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[1] = 32'h0000_0013;
   end

   // Synchronous SRAM: read data valid in the cycle after the command.
   always @(posedge clk)
      if (sram_e && sram_we == 4'b0000) sram_rd <= mem[sram_a[3:0]];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      ins_req = 0; ins_a = 0;
      dat_req = 0; dat_we = 0; dat_be = 0; dat_a = 0; dat_wd = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        ir;
      logic [15:0] ia;
      logic        dr;
      logic        dw;
      logic [3:0]  be;
      logic [15:0] da;
      logic [31:0] wd;
      logic [1:0]  gnt;
      logic        e;
      logic [13:0] a;
      logic [3:0]  we;
      logic [31:0] wdo;
   } vec_t;

   vec_t tv [8];
   logic seen;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,
                2'b10, 1'b1, 14'd1, 4'h0, 32'h0};
      tv[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b0011, 16'h0010, 32'hAABBCCDD,
                2'b01, 1'b1, 14'd4, 4'b0011, 32'hAABBCCDD};
      tv[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,
                2'b00, 1'b0, 14'd4, 4'h0, 32'hAABBCCDD};
      tv[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'hF, 16'h0022, 32'h11111111,
                2'b01, 1'b1, 14'd8, 4'h0, 32'h11111111};
      tv[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'h0, 16'h003C, 32'h00000055,
                2'b01, 1'b1, 14'd15, 4'h0, 32'h00000055};
      tv[5] = '{1'b1, 16'h0200, 1'b1, 1'b1, 4'hF, 16'h0040, 32'hCAFEF00D,
                2'b01, 1'b1, 14'd16, 4'hF, 32'hCAFEF00D};
      tv[6] = '{1'b1, 16'h0104, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,
                2'b10, 1'b1, 14'h041, 4'h0, 32'hCAFEF00D};
      tv[7] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,
                2'b10, 1'b1, 14'h3FFF, 4'h0, 32'hCAFEF00D};

      // Reset state, with both requests high to prove gnt is masked.
      rst = 1'b1;
      idle();
      ins_req = 1'b1;
      dat_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd", 64'({ins_gnt, dat_gnt, sram_e, sram_a, sram_we, sram_wd}),
          64'h0);
      chk("rst_ret", 64'({ins_rvalid, dat_rvalid, conflict_cnt}), 64'h0);
      chk("rst_rdata", {ins_rdata, dat_rdata}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();

      // Vector table.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ins_req = tv[i].ir; ins_a = tv[i].ia;
         dat_req = tv[i].dr; dat_we = tv[i].dw; dat_be = tv[i].be;
         dat_a = tv[i].da; dat_wd = tv[i].wd;
         #1;
         chk($sformatf("vec%0d_gnt", i), 64'({ins_gnt, dat_gnt}),
             64'(tv[i].gnt));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_cmd", i),
             64'({sram_e, sram_a, sram_we, sram_wd}),
             64'({tv[i].e, tv[i].a, tv[i].we, tv[i].wdo}));
      end

      // Fetch latency; grant in first cycle after reset release.
      do_reset();
      ins_req = 1'b1;
      ins_a   = 16'h0004;
      #1;
      chk("first_gnt", 64'(ins_gnt), 64'h1);
      @(posedge clk);
      #1;
      chk("fetch_cmd", 64'({sram_e, sram_a, sram_we}), 64'({1'b1, 14'd1, 4'h0}));
      @(negedge clk);
      idle();
      @(posedge clk);
      #1;
      chk("fetch_e1", 64'(ins_rvalid), 64'h0);
      @(posedge clk);
      #1;
      chk("fetch_e2", 64'({dat_rvalid, ins_rvalid, ins_rdata}),
          64'({1'b0, 1'b1, 32'h00000013}));
      @(posedge clk);
      #1;
      chk("fetch_hold", 64'({ins_rvalid, ins_rdata}), 64'({1'b0, 32'h13}));

      // Store returns nothing.
      @(negedge clk);
      dat_req = 1'b1; dat_we = 1'b1; dat_be = 4'b0011;
      dat_a = 16'h0010; dat_wd = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk);
      idle();
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         seen = seen | dat_rvalid | ins_rvalid;
      end
      chk("store_no_rvalid", 64'(seen), 64'h0);

      // Starvation rotation: D D D D F repeating.
      do_reset();
      ins_req = 1'b1; ins_a = 16'h0100;
      dat_req = 1'b1; dat_we = 1'b0; dat_a = 16'h0200;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("starve_c%0d", i), 64'({ins_gnt, dat_gnt}),
             (i % 5 == 4) ? 64'h2 : 64'h1);
         @(posedge clk);
         @(negedge clk);
      end
      idle();
      chk("conflict_10", 64'(conflict_cnt), 64'd10);

      // Alternating fetch/load; returns in accept order.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         idle();
         if (k < 4) begin
            if (k % 2 == 0) begin
               ins_req = 1'b1;
               ins_a   = 16'(4 * (2 + k));
            end else begin
               dat_req = 1'b1;
               dat_a   = 16'(4 * (2 + k));
            end
         end
         @(posedge clk);
         #1;
         if (k >= 2) begin
            chk($sformatf("alt%0d_valid", k - 2),
                64'({ins_rvalid, dat_rvalid}),
                (k % 2 == 0) ? 64'h2 : 64'h1);
            chk($sformatf("alt%0d_data", k - 2),
                64'((k % 2 == 0) ? ins_rdata : dat_rdata),
                64'(32'h1000_0000 + 32'(k)));
         end
      end
      @(negedge clk);
      idle();

      // Reset one cycle after a load accept.
      do_reset();
      dat_req = 1'b1; dat_we = 1'b0; dat_a = 16'h0018;
      @(posedge clk);
      @(negedge clk);
      idle();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      ins_req = 1'b1;
      dat_req = 1'b1;
      #1;
      chk("midrst_cmd",
          64'({ins_gnt, dat_gnt, sram_e, sram_a, sram_we, sram_wd}), 64'h0);
      chk("midrst_ret", 64'({ins_rvalid, dat_rvalid, conflict_cnt}), 64'h0);
      chk("midrst_rdata", {ins_rdata, dat_rdata}, 64'h0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle();
      dat_req = 1'b1; dat_we = 1'b1; dat_be = 4'hF; dat_a = 16'h0020;
      #1;
      chk("post_rst_gnt", 64'(dat_gnt), 64'h1);
      @(negedge clk);
      idle();
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         seen = seen | dat_rvalid;
      end
      chk("midrst_no_rvalid", 64'(seen), 64'h0);

      // Conflict counter saturation.
      @(negedge clk);
      force dut.conflict_q = 16'hFFFE;
      #1;
      release dut.conflict_q;
      ins_req = 1'b1;
      dat_req = 1'b1;
      @(posedge clk);
      #1;
      chk("conflict_ffff", 64'(conflict_cnt), 64'hFFFF);
      repeat (2) @(posedge clk);
      #1;
      chk("conflict_sat", 64'(conflict_cnt), 64'hFFFF);
      @(negedge clk);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
